// File: rtl/csa_sub_seq.sv
// Sequential carry-select subtractor: diff = a + ~b + 1, one BLOCK_W slice per cycle.
// Each slice evaluates carry-in 0 and carry-in 1 in parallel. The registered carry
// picks one of the two results, and the picked carry-out becomes the next carry.
module csa_sub_seq #(
  parameter int WIDTH   = 6,
  parameter int BLOCK_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  localparam int NBLK = WIDTH / BLOCK_W;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBLK - 1);

  generate
    if ((BLOCK_W < 1) || (WIDTH % BLOCK_W != 0)) begin : g_bad_cfg
      $error("csa_sub_seq: WIDTH must be a positive multiple of BLOCK_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_borrow;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [31:0]        w_base;
  logic [BLOCK_W-1:0] w_a_blk;
  logic [BLOCK_W-1:0] w_nb_blk;
  logic [BLOCK_W:0]   w_s0;
  logic [BLOCK_W:0]   w_s1;
  logic [BLOCK_W:0]   w_sel;

  // Current slice: both carry hypotheses computed side by side, selected by r_carry
  always_comb begin
    w_base   = 32'(r_idx) * 32'(BLOCK_W);
    w_a_blk  = r_a[w_base +: BLOCK_W];
    w_nb_blk = ~r_b[w_base +: BLOCK_W];
    w_s0     = {1'b0, w_a_blk} + {1'b0, w_nb_blk};
    w_s1     = {1'b0, w_a_blk} + {1'b0, w_nb_blk} + (BLOCK_W+1)'(1);
    w_sel    = r_carry ? w_s1 : w_s0;
  end

  // Control FSM and datapath registers; the handshake outputs are registered with the state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b1;
      r_borrow    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_a        <= i_sub_term1;
            r_b        <= i_sub_term2;
            r_carry    <= 1'b1;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_diff[w_base +: BLOCK_W] <= w_sel[BLOCK_W-1:0];
          r_carry                   <= w_sel[BLOCK_W];
          if (r_idx == LAST_IDX) begin
            r_borrow    <= ~w_sel[BLOCK_W];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_diff      = r_diff;
  assign o_borrow    = r_borrow;

endmodule

// File: tb/tb_csa_sub_seq.sv
// Bench for csa_sub_seq: directed corners, backpressure, reset abort, random pairs.
module tb_csa_sub_seq;
  localparam int WIDTH   = 6;
  localparam int BLOCK_W = 2;
  localparam int NBLK    = WIDTH / BLOCK_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] t1;
  logic [WIDTH-1:0] t2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  int checks = 0;
  int errors = 0;

  // expected {borrow, diff}, pushed at accept, popped at result
  logic [WIDTH:0] sb_q[$];

  csa_sub_seq #(.WIDTH(WIDTH), .BLOCK_W(BLOCK_W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_sub_term1 (t1),
    .i_sub_term2 (t2),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_diff      (diff),
    .o_borrow    (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: unsigned difference mod 2^WIDTH and unsigned borrow
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] d;
    d = a - b;
    return {(a < b), d};
  endfunction

  // Accept one operand pair and return once the result has been seen.
  // Leaves the bench at the negedge where out_valid was first observed.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output bit ok);
    int cyc;
    ok = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL ready_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    in_valid = 1'b1; t1 = a; t2 = b;
    sb_q.push_back(ref_sub(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== NBLK) begin
      errors++;
      $display("FAIL latency a=%0d b=%0d: got %0d cycles required %0d", a, b, cyc, NBLK);
    end
    if (!out_valid) begin
      void'(sb_q.pop_front());
      return;
    end
    ok = 1'b1;
  endtask

  // Compare the presented result against the scoreboard head
  task automatic check_result(input string name);
    logic [WIDTH:0] exp;
    exp = sb_q.pop_front();
    checks++;
    if ({borrow, diff} !== exp || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: diff=%0d borrow=%0b in_ready=%0b required diff=%0d borrow=%0b in_ready=0",
               name, diff, borrow, in_ready, exp[WIDTH-1:0], exp[WIDTH]);
    end
  endtask

  // After the handshake, the block must be back in IDLE next cycle
  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: out_valid=%0b in_ready=%0b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
    bit ok;
    issue(a, b, ok);
    if (ok) begin
      check_result(name);
      check_idle(name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; t1 = '0; t2 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset: out_valid=%0b in_ready=%0b diff=%0d borrow=%0b required 0/1/0/0",
               out_valid, in_ready, diff, borrow);
    end
  endtask

  task automatic test_directed();
    run_op(6'd45, 6'd12, "sub_45_12");
    run_op(6'd12, 6'd45, "sub_12_45");
    run_op(6'd0,  6'd1,  "sub_0_1");
    run_op(6'd63, 6'd63, "sub_63_63");
    run_op(6'd0,  6'd0,  "sub_0_0");
    run_op(6'd63, 6'd0,  "sub_63_0");
    run_op(6'd0,  6'd63, "sub_0_63");
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [WIDTH-1:0] hd;
    logic             hb;
    out_ready = 1'b0;
    issue(6'd20, 6'd33, ok);
    if (ok) begin
      hd = diff; hb = borrow;
      check_result("bp_result");
      // offer a competing operand while stalled; it must not be taken
      in_valid = 1'b1; t1 = 6'd1; t2 = 6'd2;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== hd || borrow !== hb) begin
          errors++;
          $display("FAIL bp_hold%0d: out_valid=%0b in_ready=%0b diff=%0d borrow=%0b required 1/0/%0d/%0b",
                   i, out_valid, in_ready, diff, borrow, hd, hb);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check_idle("bp");
      // no stray op may be in flight: stays idle
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_no_accept: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1; t1 = 6'd50; t2 = 6'd7;
    @(negedge clk);            // accepted; first RUN cycle
    in_valid = 1'b0;
    @(negedge clk);            // second RUN cycle
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%0b in_ready=%0b diff=%0d borrow=%0b required 0/1/0/0",
               out_valid, in_ready, diff, borrow);
    end
    // aborted op must not surface later
    repeat (NBLK + 1) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_no_result: out_valid=%0b required 0", out_valid);
      end
    end
    run_op(6'd50, 6'd7, "after_reset");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 2000; i++) begin
      a = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      b = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      run_op(a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // never both handshakes high at once
  always @(negedge clk) begin
    if (rst_n && in_ready && out_valid) begin
      errors++;
      $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 required not both");
    end
  end

endmodule
